sdram_port_arbiter: RTL and testbench

// Shares the single byte-wide SDRAM controller port between the artwork loader (write-only,

---
 rtl/sdram_port_arbiter_pkg.sv | 21 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/sdram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared constants and FSM state type for the SDRAM port arbiter slice.
package sdram_port_arbiter_pkg;

  localparam int unsigned AW_DEF      = 25;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned WD_W        = 8;

  // Artwork plane layout in SDRAM; offsets are applied by the requesters.
  localparam int unsigned BG_BASE   = 0;
  localparam int unsigned MASK_BASE = 640 * 480;
  localparam int unsigned PLANE_END = 2 * 640 * 480;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: clears while idle, counts while a request is open,
// and flags expiry in the TIMEOUT-th cycle of an open request.
module arb_watchdog
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the byte-wide SDRAM controller port between the artwork loader
// (writes) and the VFD compositor (reads), throttling the compositor via vfd_rdy.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ld_busy_i,
  input  logic          ld_wr_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  output logic          ld_wait_o,
  input  logic          vfd_rd_i,
  input  logic [AW-1:0] vfd_addr_i,
  output logic [DW-1:0] vfd_data_o,
  output logic          vfd_rdy_o,
  output logic          sd_req_o,
  output logic          sd_we_o,
  output logic [AW-1:0] sd_addr_o,
  output logic [DW-1:0] sd_din_o,
  input  logic [DW-1:0] sd_dout_i,
  input  logic          sd_ack_i,
  output logic          err_o
);

  state_e          state_q, state_d;
  logic            ld_wait_q, ld_wait_d;
  logic [AW-1:0]   ld_addr_q, ld_addr_d;
  logic [DW-1:0]   ld_data_q, ld_data_d;
  logic            rd_pend_q, rd_pend_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0]   vfd_data_q, vfd_data_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic            wd_clr, wd_en, wd_expire;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    ld_wait_d  = ld_wait_q;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    vfd_data_d = vfd_data_q;
    err_d      = err_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    // Strobes arriving while the matching side is busy are dropped.
    if (ld_wr_i && !ld_wait_q) begin
      ld_wait_d = 1'b1;
      ld_addr_d = ld_addr_i;
      ld_data_d = ld_data_i;
    end
    if (vfd_rd_i && rdy_q) begin
      rd_pend_d = 1'b1;
      rd_addr_d = vfd_addr_i;
    end

    unique case (state_q)
      IDLE: begin
        wd_clr = 1'b1;
        if (ld_wait_q) begin
          state_d = WR;
        end else if (rd_pend_q && !ld_busy_i) begin
          state_d = RD;
        end
      end
      WR: begin
        wd_en = 1'b1;
        if (sd_ack_i || wd_expire) begin
          ld_wait_d = 1'b0;
          err_d     = err_q | ~sd_ack_i;
          state_d   = IDLE;
        end
      end
      RD: begin
        wd_en = 1'b1;
        if (sd_ack_i) begin
          vfd_data_d = sd_dout_i;
          state_d    = DONE;
        end else if (wd_expire) begin
          vfd_data_d = '0;
          err_d      = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        rd_pend_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Freeze the compositor while a read is outstanding or the loader owns the port.
    rdy_d = ~(rd_pend_d | ld_busy_i | ld_wait_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ld_wait_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      vfd_data_q <= '0;
      rdy_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_wait_q  <= ld_wait_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      vfd_data_q <= vfd_data_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  assign sd_req_o   = (state_q == WR) || (state_q == RD);
  assign sd_we_o    = (state_q == WR);
  assign sd_addr_o  = (state_q == WR) ? ld_addr_q :
                      (state_q == RD) ? rd_addr_q : '0;
  assign sd_din_o   = (state_q == WR) ? ld_data_q : '0;
  assign ld_wait_o  = ld_wait_q;
  assign vfd_data_o = vfd_data_q;
  assign vfd_rdy_o  = rdy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed and randomized checks of sdram_port_arbiter against a queue-based
// transaction-order and latency model; the bench plays the SDRAM controller.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_busy, ld_wr, ld_wait;
  logic [24:0] ld_addr, vfd_addr, sd_addr;
  logic [7:0]  ld_data, vfd_data, sd_din, sd_dout;
  logic        vfd_rd, vfd_rdy, sd_req, sd_we, sd_ack, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit          we;
    logic [24:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t expq[$];

  sdram_port_arbiter #(
    .AW(25),
    .DW(8),
    .TIMEOUT(255)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .ld_busy_i (ld_busy),
    .ld_wr_i   (ld_wr),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .ld_wait_o (ld_wait),
    .vfd_rd_i  (vfd_rd),
    .vfd_addr_i(vfd_addr),
    .vfd_data_o(vfd_data),
    .vfd_rdy_o (vfd_rdy),
    .sd_req_o  (sd_req),
    .sd_we_o   (sd_we),
    .sd_addr_o (sd_addr),
    .sd_din_o  (sd_din),
    .sd_dout_i (sd_dout),
    .sd_ack_i  (sd_ack),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (sd_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_seen", 32'(sd_req), 32'd1);
  endtask

  // Controller side: ack arrives in the L-th cycle of an open request.
  task automatic serve(input int lat, input logic [7:0] dout);
    for (int k = 1; k < lat; k++) begin
      tick();
      check("req_hold", 32'(sd_req), 32'd1);
    end
    sd_ack  = 1'b1;
    sd_dout = dout;
    tick();
    sd_ack  = 1'b0;
    sd_dout = 8'h00;
    check("req_drop", 32'(sd_req), 32'd0);
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (vfd_rdy !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("rdy_seen", 32'(vfd_rdy), 32'd1);
  endtask

  initial begin
    int s, n, exp_rise, lat, mode;
    logic [7:0]  exp_data, dout;
    logic [24:0] wa, ra;
    logic [7:0]  wd;
    txn_t t;

    rst_n = 1'b0; ld_busy = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    vfd_rd = 1'b0; vfd_addr = '0; sd_dout = '0; sd_ack = 1'b0;
    repeat (3) tick();
    check("rst_rdy", 32'(vfd_rdy), 32'd1);
    check("rst_req", 32'(sd_req), 32'd0);
    check("rst_we", 32'(sd_we), 32'd0);
    check("rst_wait", 32'(ld_wait), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data", 32'(vfd_data), 32'd0);
    check("rst_addr", 32'(sd_addr), 32'd0);
    check("rst_din", 32'(sd_din), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Idle for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_rdy", 32'(vfd_rdy), 32'd1);
      check("idle_req", 32'(sd_req), 32'd0);
      check("idle_err", 32'(err), 32'd0);
    end

    // 2. Single read, ack latency 2.
    s = cyc; vfd_rd = 1'b1; vfd_addr = 25'h4B001;
    tick(); vfd_rd = 1'b0;
    check("rd_rdy_drop", 32'(vfd_rdy), 32'd0);
    wait_req();
    check("rd_addr", 32'(sd_addr), 32'h4B001);
    check("rd_we", 32'(sd_we), 32'd0);
    serve(2, 8'h5A);
    check("rd_rdy_done", 32'(vfd_rdy), 32'd0);
    wait_rdy();
    check("rd_latency", 32'(cyc - s), 32'd5);
    check("rd_data", 32'(vfd_data), 32'h5A);

    // 3. Write and read strobed together: write goes first.
    ld_wr = 1'b1; ld_addr = 25'h000010; ld_data = 8'hC3;
    vfd_rd = 1'b1; vfd_addr = 25'h4B000;
    tick(); ld_wr = 1'b0; vfd_rd = 1'b0;
    check("both_wait", 32'(ld_wait), 32'd1);
    check("both_rdy", 32'(vfd_rdy), 32'd0);
    wait_req();
    check("both_w_we", 32'(sd_we), 32'd1);
    check("both_w_addr", 32'(sd_addr), 32'h10);
    check("both_w_din", 32'(sd_din), 32'hC3);
    serve(1, 8'h00);
    check("both_wait_clr", 32'(ld_wait), 32'd0);
    check("both_rdy_held", 32'(vfd_rdy), 32'd0);
    wait_req();
    check("both_r_we", 32'(sd_we), 32'd0);
    check("both_r_addr", 32'(sd_addr), 32'h4B000);
    serve(1, 8'h3C);
    wait_rdy();
    check("both_r_data", 32'(vfd_data), 32'h3C);

    // 4. Read accepted as the download starts; held until ld_busy falls.
    ld_busy = 1'b1; vfd_rd = 1'b1; vfd_addr = 25'h0ABCDE;
    tick(); vfd_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin vfd_rd = 1'b1; vfd_addr = 25'h1111; end
      if (i == 5) vfd_rd = 1'b0;
      check("busy_req", 32'(sd_req), 32'd0);
      check("busy_rdy", 32'(vfd_rdy), 32'd0);
      tick();
    end
    ld_busy = 1'b0;
    tick();
    check("busy_rel_req", 32'(sd_req), 32'd1);
    check("busy_rel_addr", 32'(sd_addr), 32'h0ABCDE);
    serve(1, 8'h77);
    wait_rdy();
    check("busy_data", 32'(vfd_data), 32'h77);
    ld_busy = 1'b1;
    tick();
    check("busy_only_rdy0", 32'(vfd_rdy), 32'd0);
    ld_busy = 1'b0;
    tick();
    check("busy_only_rdy1", 32'(vfd_rdy), 32'd1);

    // 5. Read timeout, then write timeout.
    vfd_rd = 1'b1; vfd_addr = 25'h123;
    tick(); vfd_rd = 1'b0;
    wait_req();
    n = 0;
    while (sd_req === 1'b1 && n < 400) begin tick(); n++; end
    check("rto_req_cycles", 32'(n), 32'd255);
    check("rto_err", 32'(err), 32'd1);
    check("rto_data", 32'(vfd_data), 32'd0);
    tick();
    check("rto_rdy", 32'(vfd_rdy), 32'd1);
    ld_wr = 1'b1; ld_addr = 25'h1ABCDEF; ld_data = 8'h99;
    tick(); ld_wr = 1'b0;
    wait_req();
    n = 0;
    while (sd_req === 1'b1 && n < 400) begin tick(); n++; end
    check("wto_req_cycles", 32'(n), 32'd255);
    check("wto_wait", 32'(ld_wait), 32'd0);
    check("wto_err", 32'(err), 32'd1);

    // 6. Asynchronous reset in the middle of a write.
    ld_wr = 1'b1; ld_addr = 25'h123; ld_data = 8'h44;
    tick(); ld_wr = 1'b0;
    wait_req();
    check("arst_pre_we", 32'(sd_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(sd_req), 32'd0);
    check("arst_wait", 32'(ld_wait), 32'd0);
    check("arst_rdy", 32'(vfd_rdy), 32'd1);
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized: order, fields, returned data and compositor latency.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      wa = 25'($urandom); wd = 8'($urandom); ra = 25'($urandom);
      s = cyc;
      if (mode != 0) begin
        ld_wr = 1'b1; ld_addr = wa; ld_data = wd;
        expq.push_back('{we: 1'b1, addr: wa, data: wd});
      end
      if (mode != 1) begin
        vfd_rd = 1'b1; vfd_addr = ra;
        expq.push_back('{we: 1'b0, addr: ra, data: 8'h00});
      end
      tick(); ld_wr = 1'b0; vfd_rd = 1'b0;
      exp_rise = s + 3;
      exp_data = 8'h00;
      while (expq.size() > 0) begin
        t = expq.pop_front();
        wait_req();
        check("rnd_we", 32'(sd_we), 32'(t.we));
        check("rnd_addr", 32'(sd_addr), 32'(t.addr));
        if (t.we) check("rnd_din", 32'(sd_din), 32'(t.data));
        lat  = $urandom_range(1, 5);
        dout = 8'($urandom);
        serve(lat, dout);
        if (t.we) begin
          check("rnd_wait_clr", 32'(ld_wait), 32'd0);
          check("rnd_rdy_after_wr", 32'(vfd_rdy), 32'(mode == 1));
          exp_rise += lat + 1;
        end else begin
          exp_data = dout;
          exp_rise += lat;
        end
      end
      if (mode != 1) begin
        wait_rdy();
        check("rnd_rdy_cycle", 32'(cyc), 32'(exp_rise));
        check("rnd_data", 32'(vfd_data), 32'(exp_data));
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    check("rnd_err_clear", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
